// File: rtl/clken_pkg.sv
// clken_pkg: shared types and helpers for the clock-enable generator.
// FSM state encoding, lost-counter width, stability-counter sizing.
package clken_pkg;

  typedef enum logic [1:0] {
    CK_WAIT_LOCK,
    CK_STABLE,
    CK_RUN
  } ck_state_t;

  localparam int LOST_W = 8;

  function automatic int stab_w(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/clken_div.sv
// clken_div: one channel's divider with glitch-free divisor reprogramming.
// c counts 0..d, ce is high in the cycle where c is 0.
module clken_div
  import clken_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             we,
  output logic             ce
);

  localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] p;
  logic [DIV_W-1:0] c;
  logic [DIV_W-1:0] c_nxt;
  logic             pend;
  logic             act;
  logic             tc;

  assign tc = (c == d);

  // First RUN cycle always starts at phase 0 so channels align.
  always_comb begin
    c_nxt = '0;
    if (act && !tc) c_nxt = c + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act <= 1'b0;
      c   <= '0;
      ce  <= 1'b0;
    end else begin
      act <= run;
      if (run) begin
        c  <= c_nxt;
        ce <= (c_nxt == '0);
      end else begin
        c  <= '0;
        ce <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d    <= DEF_D;
      p    <= DEF_D;
      pend <= 1'b0;
    end else if (!act) begin
      if (we) begin
        d    <= div;
        p    <= div;
        pend <= 1'b0;
      end
    end else if (we && tc) begin
      d    <= div;
      p    <= div;
      pend <= 1'b0;
    end else if (we) begin
      p    <= div;
      pend <= 1'b1;
    end else if (tc && pend) begin
      d    <= p;
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/clken_gen.sv
// clken_gen: lock qualification, downstream reset and N clock enables.
// Optional lock-loss counter enabled by defining CLKEN_LOSTCNT_EN.
module clken_gen
  import clken_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                      clkin,
  input  logic                      rst,
  input  logic                      locked,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic [CHANNELS-1:0]       div_we,
  output logic [CHANNELS-1:0]       ce,
  output logic                      rst_out,
  output logic                      ready,
  output logic [LOST_W-1:0]         lost_cnt
);

  localparam int SW = stab_w(LOCK_CYCLES);
  localparam logic [SW-1:0] STAB_END = SW'(LOCK_CYCLES - 1);

  ck_state_t state;
  ck_state_t state_nxt;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_nxt;
  logic lk_m;
  logic lk_s;
  logic run;

  always_ff @(posedge clkin) begin
    if (rst) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= locked;
      lk_s <= lk_m;
    end
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    unique case (state)
      CK_WAIT_LOCK: begin
        if (lk_s) begin
          state_nxt = CK_STABLE;
          stab_nxt  = '0;
        end
      end
      CK_STABLE: begin
        if (!lk_s) state_nxt = CK_WAIT_LOCK;
        else if (stab == STAB_END) state_nxt = CK_RUN;
        else stab_nxt = stab + 1'b1;
      end
      CK_RUN: begin
        if (!lk_s) state_nxt = CK_WAIT_LOCK;
      end
      default: state_nxt = CK_WAIT_LOCK;
    endcase
  end

  // Outputs follow the next state so they change on the entry edge.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state   <= CK_WAIT_LOCK;
      stab    <= '0;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      stab    <= stab_nxt;
      rst_out <= (state_nxt != CK_RUN);
      ready   <= (state_nxt == CK_RUN);
    end
  end

`ifdef CLKEN_LOSTCNT_EN
  always_ff @(posedge clkin) begin
    if (rst) begin
      lost_cnt <= '0;
    end else if (state == CK_RUN && !lk_s && lost_cnt != '1) begin
      lost_cnt <= lost_cnt + 1'b1;
    end
  end
`else
  assign lost_cnt = '0;
`endif

  assign run = (state_nxt == CK_RUN);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clken_div #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_div (
      .clk(clkin),
      .rst(rst),
      .run(run),
      .div(div[i*DIV_W +: DIV_W]),
      .we (div_we[i]),
      .ce (ce[i])
    );
  end

endmodule

// File: doc/clken_gen.md
# clken_gen

Parametrised clock-enable and reset-sequencing block on the single system clock, replacing fixed multi-output PLL clocking with N programmable clock-enable strobes. It qualifies the PLL `locked` signal, holds a synchronous downstream reset until lock has been stable for a set time, and then runs per-channel dividers. Divisors can be reprogrammed at runtime without glitches. It sits between the board PLL wrapper and all rate-divided logic (video, CPU, peripherals).

## Interface
- `CHANNELS`, 3: number of clock-enable outputs (1..8)
- `DIV_W`, 8: divisor width per channel
- `LOCK_CYCLES`, 1024: consecutive synchronised-locked cycles required before release (≥2)
- `DEFAULT_DIV`, 1: divisor loaded into every channel on `rst`

- `clkin`  in  1  system clock, the only clock
- `rst`  in  1  reset, synchronous, active-high
- `locked`  in  1  PLL lock, asynchronous to `clkin`
- `div`  in  CHANNELS*DIV_W  new divisors, channel i at `[i*DIV_W +: DIV_W]`
- `div_we`  in  CHANNELS  per-channel divisor write strobe
- `ce`  out  CHANNELS  one-cycle clock-enable strobes
- `rst_out`  out  1  synchronous active-high reset for downstream logic
- `ready`  out  1  high while in RUN
- `lost_cnt`  out  8  saturating count of lock losses while in RUN

## Operation
- `locked` passes through a 2-flop synchroniser (`lk_s`); the synchroniser is cleared by `rst`.
- FSM states: WAIT_LOCK, STABLE, RUN. `rst` forces WAIT_LOCK.
- WAIT_LOCK: `lk_s`=1 → STABLE with stability counter = 0.
- STABLE: `lk_s`=0 → WAIT_LOCK. Otherwise the counter increments; at counter = LOCK_CYCLES-1 → RUN.
- RUN: `lk_s`=0 → WAIT_LOCK and `lost_cnt` increments, saturating at 255.
- `rst_out` is registered `state != RUN` and `ready` is registered `state == RUN`.
- Per channel: active divisor `d`, pending divisor `p`, phase counter `c` (DIV_W bits).
  - Outside RUN: `c`=0, `ce`=0, and a write loads both `p` and `d` immediately.
  - In RUN: `ce[i]` = (`c` == 0). `c` increments and wraps to 0 after reaching `d`, so the period is `d`+1 cycles.
  - `d`=0 → `ce[i]` held high every RUN cycle.
- Runtime write in RUN: `div_we[i]` captures `div` into `p` and sets a pending flag.
  - At the cycle where `c` == `d`, `d` ← `p` and the flag clears, so the new period starts at the next `c`=0.
  - For `d`=0 the new divisor takes effect on the cycle after the write.
- Simultaneous write and terminal count on the same cycle: the written value becomes the new `d` directly; the write is never lost.
- A repeated write before application overwrites `p`; the last write wins.
- `rst` mid-run: next cycle `ce`=0, `rst_out`=1, `ready`=0, `d`=`p`=DEFAULT_DIV, `lost_cnt`=0.

## Timing
- Reset values: `ce`=0, `rst_out`=1, `ready`=0, `lost_cnt`=0, state = WAIT_LOCK.
- Release latency: `rst_out` falls LOCK_CYCLES+3 `clkin` edges after the first edge that samples `locked`=1. This is 2 synchroniser edges + 1 edge into STABLE + LOCK_CYCLES edges into RUN, with registered outputs updating on the RUN-entry edge.
- First `ce` on every channel is in the same cycle `rst_out` first reads 0, so all channels start phase-aligned.
- Lock loss: `rst_out` rises and `ce` stops 3 edges after `locked` falls. `lost_cnt` updates on the same edge.
- `ce` is driven directly from registers with no combinational path from inputs.

## Configuration
- `CLKEN_LOSTCNT_EN`
  - Defined: `lost_cnt` counter implemented as above.
  - Undefined: counter logic removed and `lost_cnt` tied to 0. All other behaviour is identical.

## Structure
- Package `clken_pkg`:
  - FSM state enum (`CK_WAIT_LOCK`, `CK_STABLE`, `CK_RUN`).
  - Lost-counter width constant (8).
  - Stability-counter width function `$clog2(LOCK_CYCLES)`.
- Sub-module `clken_div`: one channel's `d`/`p`/`c`/pending logic. Inputs are `run`, `div`, `we`; output is `ce`. `clken_gen` instantiates it CHANNELS times in a generate loop.
- `clken_gen` holds the synchroniser, the FSM, the stability counter and the lost counter.

## Test plan
1. Lock release: LOCK_CYCLES=16, `locked` rises → `rst_out` falls exactly 19 edges later; `ready` rises on the same edge; all `ce` high that cycle.
2. Divide pattern: divisors {0,1,4} → `ce[0]` constant 1, `ce[1]` every 2nd cycle, `ce[2]` every 5th cycle, all phase-aligned at release.
3. Glitch-free reprogram: channel 2 `d`=4 with write of 2 at `c`=1 → current 5-cycle period completes, then period 3. No short or double pulse.
4. Write on terminal count: write 7 in the cycle `c`==`d` → the next period is 8 cycles.
5. Lock drop: in RUN, `locked` drops for 1 cycle → `rst_out`=1 three edges later, `lost_cnt`=1. Re-release after 19 edges. Drop `locked` 300 times → `lost_cnt` saturates at 255.
6. Mid-run `rst` and STABLE abort:
   - `rst` pulse in RUN → next cycle `ce`=0, `rst_out`=1, divisors back to DEFAULT_DIV.
   - `locked` drops at stability count 10 → no release; the count restarts from 0.
